// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with prescaler, edge/center-aligned counting
// and double-buffered duty registers that swap only at period boundaries.
module pwm_multi #(
    parameter int unsigned CH = 4,
    parameter int unsigned N  = 8,
    parameter int unsigned PW = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   center,
    input  logic [PW-1:0]          prescale,
    input  logic                   wr_en,
    input  logic [$clog2(CH)-1:0]  wr_ch,
    input  logic [N-1:0]           wr_duty,
    output logic                   wr_ready,
    output logic [CH-1:0]          pwm_out,
    output logic                   period_tick,
    output logic [N-1:0]           cnt
);

    localparam int unsigned CW = $clog2(CH);
    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

    logic [PW-1:0] pdiv;
    logic          dir_down;
    logic          dir_next;
    logic          mode_q;
    logic [N-1:0]  cnt_next;
    logic          tick;
    logic          boundary;
    logic          wr_accept;
    logic [CH-1:0] pending;
    logic [N-1:0]  shadow      [CH];
    logic [N-1:0]  active      [CH];
    logic [N-1:0]  active_next [CH];

    assign tick      = en && (pdiv == prescale);
    assign wr_accept = wr_en && wr_ready;

    // Counter sequencing; a boundary always restarts the period at 0 counting up
    always_comb begin
        cnt_next = cnt;
        dir_next = dir_down;
        boundary = 1'b0;
        if (tick) begin
            if (!mode_q) begin
                cnt_next = cnt + N'(1);
                boundary = (cnt == CNT_MAX);
            end else if (!dir_down) begin
                if (cnt == CNT_MAX) begin
                    cnt_next = cnt - N'(1);
                    dir_next = 1'b1;
                end else begin
                    cnt_next = cnt + N'(1);
                end
            end else begin
                cnt_next = cnt - N'(1);
                boundary = (cnt == N'(1));
            end
            if (boundary) begin
                cnt_next = '0;
                dir_next = 1'b0;
            end
        end
    end

    // Out-of-range channels never match, so they see wr_ready low
    always_comb begin
        wr_ready = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (wr_ch == CW'(i)) begin
                wr_ready = !pending[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            active_next[i] = (boundary && pending[i]) ? shadow[i] : active[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pdiv        <= '0;
            cnt         <= '0;
            dir_down    <= 1'b0;
            mode_q      <= 1'b0;
            pending     <= '0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            for (int unsigned i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            // A prescale lowered below pdiv clears the divider without a tick
            if (en) begin
                if (tick || (pdiv > prescale)) begin
                    pdiv <= '0;
                end else begin
                    pdiv <= pdiv + PW'(1);
                end
            end
            cnt         <= cnt_next;
            dir_down    <= dir_next;
            period_tick <= boundary;
            if (boundary) begin
                mode_q <= center;
            end
            // A write landing on a boundary cycle stays pending for the next one
            for (int unsigned i = 0; i < CH; i++) begin
                active[i] <= active_next[i];
                if (boundary && pending[i]) begin
                    pending[i] <= 1'b0;
                end
                if (wr_accept && (wr_ch == CW'(i))) begin
                    shadow[i]  <= wr_duty;
                    pending[i] <= 1'b1;
                end
                pwm_out[i] <= en && (cnt_next < active_next[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: per-period length and high-time records are
// queued by the stimulus and checked by a monitor at each period_tick.
module tb_pwm_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned PW = 4;

    typedef struct packed {
        logic [15:0]         len;
        logic [CH-1:0][7:0]  high;
    } period_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          center;
    logic [PW-1:0] prescale;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [N-1:0]  wr_duty;
    logic          wr_ready;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic [N-1:0]  cnt;

    period_t exp_q[$];
    int      n_vec = 0;
    int      n_err = 0;
    int      n;

    always #5 clk = ~clk;

    pwm_multi #(.CH(CH), .N(N), .PW(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .center     (center),
        .prescale   (prescale),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_duty    (wr_duty),
        .wr_ready   (wr_ready),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .cnt        (cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_period(input int len, input int h0, input int h1, input int h2, input int h3);
        period_t e;
        e.len     = 16'(len);
        e.high[0] = 8'(h0);
        e.high[1] = 8'(h1);
        e.high[2] = 8'(h2);
        e.high[3] = 8'(h3);
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Returns at the negedge of the cycle where period_tick is high
    task automatic wait_tick(input int limit, output int cnt_cycles);
        cnt_cycles = 0;
        do begin
            @(negedge clk);
            cnt_cycles++;
        end while (period_tick !== 1'b1 && cnt_cycles < limit);
        if (period_tick !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout: got no period_tick expected one within %0d cycles", limit);
        end
    endtask

    task automatic write(input int ch, input int duty, input logic exp_rdy, input string name);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = 4'(duty);
        #1;
        check(name, 32'(wr_ready), 32'(exp_rdy));
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Monitor: accumulate each period and compare against the queued record
    initial begin : monitor
        period_t acc;
        period_t e;
        acc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (period_tick === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (acc !== e) begin
                        n_err++;
                        $display("FAIL period: got len=%0d high[3:0]=%h expected len=%0d high[3:0]=%h",
                                 acc.len, acc.high, e.len, e.high);
                    end
                end
                acc = '0;
            end
            acc.len = acc.len + 16'd1;
            for (int i = 0; i < int'(CH); i++) begin
                acc.high[i] = acc.high[i] + 8'(pwm_out[i]);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got no finish expected finish before 50000");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset    = 1'b1;
        en       = 1'b0;
        center   = 1'b0;
        prescale = '0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_duty  = '0;
        cycles(3);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_cnt", 32'(cnt), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        #1;
        check("reset_ready", 32'(wr_ready), 32'd1);

        // Basic edge mode, ch0 = 5
        reset = 1'b0;
        en    = 1'b1;
        write(0, 5, 1'b1, "wr_ch0");
        wait_tick(40, n);
        expect_period(16, 5, 0, 0, 0);
        wait_tick(40, n);
        expect_period(16, 5, 0, 0, 0);
        wait_tick(40, n);

        // Prescaler 2, ch1 = 8
        prescale = 4'd2;
        write(1, 8, 1'b1, "wr_ch1");
        wait_tick(80, n);
        expect_period(48, 15, 24, 0, 0);
        wait_tick(80, n);
        cycles(2);
        prescale = 4'd0;
        @(negedge clk);
        check("prescale_clear_no_tick", 32'(cnt), 32'd0);
        @(negedge clk);
        check("prescale_resume", 32'(cnt), 32'd1);
        wait_tick(40, n);

        // Double buffering: refused rewrite, no mid-period change
        expect_period(16, 5, 8, 0, 0);
        cycles(4);
        write(2, 3, 1'b1, "wr_ch2_first");
        write(2, 12, 1'b0, "wr_ch2_refused");
        wait_tick(40, n);
        expect_period(16, 5, 8, 3, 0);
        write(2, 12, 1'b1, "wr_ch2_retry");
        wait_tick(40, n);

        // Center request mid-period applies at the next boundary
        expect_period(16, 5, 8, 12, 0);
        write(3, 4, 1'b1, "wr_ch3");
        cycles(4);
        center = 1'b1;
        wait_tick(40, n);
        expect_period(30, 9, 15, 23, 7);
        wait_tick(80, n);
        expect_period(30, 9, 15, 23, 7);
        center = 1'b0;
        wait_tick(80, n);

        // Extremes in edge mode
        expect_period(16, 5, 8, 12, 4);
        write(0, 0, 1'b1, "wr_ch0_zero");
        write(1, 15, 1'b1, "wr_ch1_max");
        wait_tick(40, n);
        expect_period(16, 0, 15, 12, 4);
        wait_tick(40, n);

        // Enable drop: counter frozen, outputs low, shadow writes still taken
        cycles(3);
        check("pre_freeze_cnt", 32'(cnt), 32'd3);
        en = 1'b0;
        write(3, 9, 1'b1, "wr_ch3_disabled");
        check("freeze_cnt", 32'(cnt), 32'd3);
        check("freeze_pwm", 32'(pwm_out), 32'd0);
        repeat (9) begin
            @(negedge clk);
            check("freeze_cnt", 32'(cnt), 32'd3);
            check("freeze_pwm", 32'(pwm_out), 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        check("resume_cnt", 32'(cnt), 32'd4);
        check("resume_pwm", 32'(pwm_out), 32'b0110);
        wait_tick(40, n);
        expect_period(16, 0, 15, 12, 9);
        wait_tick(40, n);

        // Reset with writes pending on every channel
        cycles(3);
        for (int i = 0; i < 4; i++) begin
            write(i, 7, 1'b1, "wr_pending");
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset_pwm", 32'(pwm_out), 32'd0);
        check("midreset_cnt", 32'(cnt), 32'd0);
        check("midreset_tick", 32'(period_tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_ch = 2'(i);
            #1;
            check("post_reset_ready", 32'(wr_ready), 32'd1);
        end
        wait_tick(40, n);
        check("first_period_len", 32'(n), 32'd16);
        expect_period(16, 0, 0, 0, 0);
        wait_tick(40, n);

        cycles(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
